// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared-buffer geometry and free-list state encoding
package mem_pkg;

   localparam int ADDR_W     = 4;
   localparam int BLOCK_BITS = 6;
   localparam int NUM_BLOCKS = 2 ** ADDR_W;

   typedef enum logic {
      FL_INIT = 1'b0,
      FL_RUN  = 1'b1
   } fl_state_e;

endpackage

// File: rtl/free_list_ram.sv
// rtl/free_list_ram.sv - block-index storage, synchronous write, combinational read
module free_list_ram #(
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free list of buffer block indices with self-initialisation
module free_list
   import mem_pkg::*;
#(
   parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
   parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fl_alloc_req_i,
   output logic              fl_alloc_gnt_o,
   output logic [ADDR_W-1:0] fl_alloc_block_idx_o,
   input  logic              fl_free_req_i,
   input  logic [ADDR_W-1:0] fl_free_block_idx_i,
   output logic [CNT_W-1:0]  fl_free_count_o,
   output logic              fl_empty_o,
   output logic              fl_init_done_o,
   output logic              fl_err_o
);

   localparam int PTR_W = $clog2(NUM_BLOCKS);
   localparam logic [ADDR_W:0]  NB_EXT = (ADDR_W + 1)'(NUM_BLOCKS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BLOCKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BLOCKS - 1);

   fl_state_e         state, state_nxt;
   logic [PTR_W-1:0]  head, tail;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              gnt_q, empty_q, err_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] ram_rdata, ram_wdata;
   logic              ram_we;
   logic              accept, free_ok, full, idx_in_range;

   assign full         = (count == CNT_FULL);
   assign idx_in_range = ({1'b0, fl_free_block_idx_i} < NB_EXT);
   // Grant register gates accept so a held request cannot be granted twice back to back.
   assign accept  = (state == FL_RUN) && fl_alloc_req_i && (count != '0) && !gnt_q;
   assign free_ok = (state == FL_RUN) && fl_free_req_i && !full && idx_in_range;

   assign ram_we    = (state == FL_INIT) || free_ok;
   assign ram_wdata = (state == FL_INIT) ? ADDR_W'(tail) : fl_free_block_idx_i;

   free_list_ram #(
      .DEPTH  (NUM_BLOCKS),
      .PTR_W  (PTR_W),
      .DATA_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (tail),
      .wdata (ram_wdata),
      .raddr (head),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nxt = state;
      if (state == FL_INIT && count == CNT_LAST) begin
         state_nxt = FL_RUN;
      end
   end

   always_comb begin
      count_nxt = count;
      if (state == FL_INIT) begin
         count_nxt = count + 1'b1;
      end else begin
         case ({free_ok, accept})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FL_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         gnt_q   <= 1'b0;
         idx_q   <= '0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         if (ram_we) begin
            tail <= tail + 1'b1;
         end
         if (accept) begin
            head  <= head + 1'b1;
            idx_q <= ram_rdata;
         end
         gnt_q   <= accept;
         count   <= count_nxt;
         empty_q <= (count_nxt == '0);
         err_q   <= err_q | (fl_free_req_i && !free_ok);
      end
   end

   assign fl_alloc_gnt_o       = gnt_q;
   assign fl_alloc_block_idx_o = idx_q;
   assign fl_free_count_o      = count;
   assign fl_empty_o           = empty_q;
   assign fl_init_done_o       = (state == FL_RUN);
   assign fl_err_o             = err_q;

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed self-checking bench for free_list with eight blocks
module tb_free_list;
   import mem_pkg::*;

   localparam int NB = 8;
   localparam int CW = 4;

   logic              clk;
   logic              rst_n;
   logic              req;
   logic              gnt;
   logic [ADDR_W-1:0] gidx;
   logic              free_req;
   logic [ADDR_W-1:0] free_idx;
   logic [CW-1:0]     count;
   logic              empty;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_errors = 0;

   free_list #(
      .NUM_BLOCKS (NB),
      .CNT_W      (CW)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .fl_alloc_req_i       (req),
      .fl_alloc_gnt_o       (gnt),
      .fl_alloc_block_idx_o (gidx),
      .fl_free_req_i        (free_req),
      .fl_free_block_idx_i  (free_idx),
      .fl_free_count_o      (count),
      .fl_empty_o           (empty),
      .fl_init_done_o       (done),
      .fl_err_o             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_gnt"},   32'(gnt),   0);
      check({tag, "_idx"},   32'(gidx),  0);
      check({tag, "_count"}, 32'(count), 0);
      check({tag, "_empty"}, 32'(empty), 1);
      check({tag, "_done"},  32'(done),  0);
      check({tag, "_err"},   32'(err),   0);
   endtask

   task automatic run_init();
      for (int i = 1; i <= NB; i++) begin
         tick();
         check("init_count", 32'(count), 32'(i));
         check("init_done", 32'(done), (i == NB) ? 1 : 0);
         check("init_empty", 32'(empty), 0);
      end
   endtask

   task automatic free_one(input int idx);
      free_req = 1'b1;
      free_idx = ADDR_W'(idx);
      tick();
      free_req = 1'b0;
   endtask

   initial begin
      int exp_q[3];
      rst_n    = 1'b0;
      req      = 1'b0;
      free_req = 1'b0;
      free_idx = '0;
      tick();
      tick();
      check_reset_vals("reset");

      rst_n = 1'b1;
      run_init();

      // drain: grants on alternate cycles, indices in init order
      req = 1'b1;
      for (int k = 0; k < NB; k++) begin
         tick();
         check("drain_gnt", 32'(gnt), 1);
         check("drain_idx", 32'(gidx), 32'(k));
         check("drain_count", 32'(count), 32'(NB - 1 - k));
         tick();
         check("drain_gap", 32'(gnt), 0);
         check("drain_hold", 32'(gidx), 32'(k));
      end
      check("drain_empty", 32'(empty), 1);
      tick();
      tick();
      check("empty_nogrant", 32'(gnt), 0);
      check("empty_count", 32'(count), 0);

      // free while empty with request pending: grant two cycles after the free
      free_one(5);
      check("ef_t1_gnt", 32'(gnt), 0);
      check("ef_t1_count", 32'(count), 1);
      tick();
      check("ef_t2_gnt", 32'(gnt), 1);
      check("ef_t2_idx", 32'(gidx), 5);
      check("ef_t2_count", 32'(count), 0);
      req = 1'b0;
      tick();
      check("ef_after_gnt", 32'(gnt), 0);

      // build count=3 holding 6,7,3
      free_one(6);
      free_one(7);
      free_one(3);
      check("sim_pre_count", 32'(count), 3);
      req      = 1'b1;
      free_req = 1'b1;
      free_idx = ADDR_W'(2);
      tick();
      req      = 1'b0;
      free_req = 1'b0;
      check("sim_gnt", 32'(gnt), 1);
      check("sim_idx", 32'(gidx), 6);
      check("sim_count", 32'(count), 3);
      tick();
      check("sim_count_hold", 32'(count), 3);
      exp_q = '{7, 3, 2};
      req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("sim_tail_gnt", 32'(gnt), 1);
         check("sim_tail_idx", 32'(gidx), 32'(exp_q[k]));
         tick();
      end
      req = 1'b0;
      check("sim_final_count", 32'(count), 0);
      check("sim_err_clean", 32'(err), 0);

      // illegal frees
      for (int k = 0; k < NB - 1; k++) free_one(k);
      check("fill7_count", 32'(count), 7);
      free_one(9);
      check("oor_err", 32'(err), 1);
      check("oor_count", 32'(count), 7);
      free_one(7);
      check("fill8_count", 32'(count), 8);
      free_one(1);
      check("full_count", 32'(count), 8);
      check("full_err", 32'(err), 1);

      // reset mid-run after three allocations
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      check_reset_vals("rst2");
      run_init();
      req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_idx", 32'(gidx), 32'(k));
         tick();
      end
      req = 1'b0;
      check("mid_count", 32'(count), 5);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      tick();
      rst_n = 1'b1;
      run_init();
      req = 1'b1;
      tick();
      check("reinit_gnt", 32'(gnt), 1);
      check("reinit_idx", 32'(gidx), 0);
      req = 1'b0;
      tick();

      // free attempted during init is rejected and flagged
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      free_one(3);
      check("init_free_err", 32'(err), 1);
      for (int k = 0; k < NB; k++) tick();
      check("init_free_count", 32'(count), NB);
      check("init_free_done", 32'(done), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
